// File: rtl/one_hot_decoder_pipe_pkg.sv
// Shared types and helpers for the pipelined one-hot decoder.
package one_hot_decoder_pipe_pkg;

   // Buffer occupancy: how many decoded beats are held (head + skid).
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_t;

   // Index width for an N-wide one-hot vector; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/one_hot_decoder_pipe_decode_comb.sv
// Combinational binary-to-one-hot decode; flags indices that have no output bit.
module onehot_decode_comb #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [W-1:0] idx,
   output logic [N-1:0] onehot,
   output logic         err
);

   // Bit-wise compare avoids a shift that could overflow when idx >= N.
   always_comb begin
      onehot = '0;
      for (int i = 0; i < N; i++) begin
         onehot[i] = (idx == W'(i));
      end
      err = (onehot == '0);
   end

endmodule

// File: rtl/one_hot_decoder_pipe.sv
// Pipelined one-hot decoder with a two-entry head/skid buffer and status counters.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   OCC_EMPTY | nothing buffered, out_valid low
//   OCC_ONE   | head holds a beat, skid free, input may accept
//   OCC_TWO   | head and skid full, input blocked
module one_hot_decoder_pipe
   import one_hot_decoder_pipe_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int CNT_W = 16,
   localparam int W     = idx_width(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_onehot,
   output logic             out_err,
   input  logic             clr,
   output logic [N-1:0]     seen,
   output logic [CNT_W-1:0] cnt
);

   occ_state_t       state, state_nxt;
   logic [N-1:0]     dec_onehot;
   logic             dec_err;
   logic [N-1:0]     head_onehot, skid_onehot;
   logic             head_err, skid_err;
   logic             accept, pop;
   logic             load_head_in, load_skid_in, move_skid;

   onehot_decode_comb #(.N(N), .W(W)) u_decode (
      .idx    (in_idx),
      .onehot (dec_onehot),
      .err    (dec_err)
   );

   // Handshake outputs and buffer load controls; in_ready sees only en and state.
   always_comb begin
      in_ready     = en & (state != OCC_TWO);
      out_valid    = (state != OCC_EMPTY);
      accept       = in_valid & in_ready;
      pop          = out_valid & out_ready;
      load_head_in = 1'b0;
      load_skid_in = 1'b0;
      move_skid    = 1'b0;
      case (state)
         OCC_EMPTY: load_head_in = accept;
         OCC_ONE: begin
            load_head_in = accept & pop;
            load_skid_in = accept & ~pop;
         end
         OCC_TWO:   move_skid = pop;
         default: ;
      endcase
   end

   // Occupancy next state.
   always_comb begin
      state_nxt = state;
      case (state)
         OCC_EMPTY: if (accept) state_nxt = OCC_ONE;
         OCC_ONE: begin
            if (accept & ~pop)      state_nxt = OCC_TWO;
            else if (pop & ~accept) state_nxt = OCC_EMPTY;
         end
         OCC_TWO:   if (pop) state_nxt = OCC_ONE;
         default:   state_nxt = OCC_EMPTY;
      endcase
   end

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= OCC_EMPTY;
      else        state <= state_nxt;
   end

   // Head and skid data registers; head only changes on load or skid move.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_onehot <= '0;
         head_err    <= 1'b0;
         skid_onehot <= '0;
         skid_err    <= 1'b0;
      end else begin
         if (load_head_in) begin
            head_onehot <= dec_onehot;
            head_err    <= dec_err;
         end else if (move_skid) begin
            head_onehot <= skid_onehot;
            head_err    <= skid_err;
         end
         if (load_skid_in) begin
            skid_onehot <= dec_onehot;
            skid_err    <= dec_err;
         end
      end
   end

   assign out_onehot = head_onehot;
   assign out_err    = head_err;

   // Status: clr wipes history first, a same-cycle pop is then counted on top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen <= '0;
         cnt  <= '0;
      end else if (clr) begin
         seen <= pop ? head_onehot : '0;
         cnt  <= pop ? CNT_W'(1) : '0;
      end else if (pop) begin
         seen <= seen | head_onehot;
         cnt  <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_one_hot_decoder_pipe.sv
// Directed bench: N=4/CNT_W=16 instance for the main paths, N=5/CNT_W=2 for
// out-of-range indices and counter wrap.
module tb_one_hot_decoder_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Instance A: N=4, CNT_W=16
   logic        a_en, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err, a_clr;
   logic [1:0]  a_in_idx;
   logic [3:0]  a_out_onehot, a_seen;
   logic [15:0] a_cnt;

   // Instance B: N=5, CNT_W=2
   logic        b_en, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err, b_clr;
   logic [2:0]  b_in_idx;
   logic [4:0]  b_out_onehot, b_seen;
   logic [1:0]  b_cnt;

   one_hot_decoder_pipe #(.N(4), .CNT_W(16)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .en(a_en),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_idx(a_in_idx),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_onehot(a_out_onehot), .out_err(a_out_err),
      .clr(a_clr), .seen(a_seen), .cnt(a_cnt)
   );

   one_hot_decoder_pipe #(.N(5), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .en(b_en),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_idx(b_in_idx),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_onehot(b_out_onehot), .out_err(b_out_err),
      .clr(b_clr), .seen(b_seen), .cnt(b_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp_stream [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [1:0] clr_idx    [7] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
   logic [2:0] b_idx      [3] = '{3'd4, 3'd0, 3'd1};
   logic [4:0] b_exp      [3] = '{5'b10000, 5'b00001, 5'b00010};

   initial begin
      rst_n = 1'b0;
      a_en = 1'b1; a_in_valid = 1'b0; a_in_idx = '0; a_out_ready = 1'b0; a_clr = 1'b0;
      b_en = 1'b1; b_in_valid = 1'b0; b_in_idx = '0; b_out_ready = 1'b0; b_clr = 1'b0;
      #12;
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_seen",      32'(a_seen),      32'd0);
      chk("rst_cnt",       32'(a_cnt),       32'd0);
      chk("rst_onehot",    32'(a_out_onehot), 32'd0);
      chk("rst_b_valid",   32'(b_out_valid), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("idle_in_ready", 32'(a_in_ready), 32'd1);
      a_en = 1'b0; #1;
      chk("idle_en0_ready", 32'(a_in_ready), 32'd0);
      a_en = 1'b1;

      // Streaming, one beat per cycle
      a_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_in_valid = 1'b1;
         a_in_idx   = 2'(i);
         step();
         chk("stream_valid",  32'(a_out_valid),  32'd1);
         chk("stream_onehot", 32'(a_out_onehot), 32'(exp_stream[i]));
         chk("stream_ready",  32'(a_in_ready),   32'd1);
      end
      a_in_valid = 1'b0;
      step();
      chk("stream_drained", 32'(a_out_valid), 32'd0);
      chk("stream_seen",    32'(a_seen),      32'hF);
      chk("stream_cnt",     32'(a_cnt),       32'd4);

      // Back-pressure
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_idx = 2'd2;
      step();
      chk("bp_ready_one",  32'(a_in_ready),   32'd1);
      chk("bp_head_first", 32'(a_out_onehot), 32'h4);
      a_in_idx = 2'd1;
      step();
      chk("bp_ready_two",  32'(a_in_ready),   32'd0);
      chk("bp_head_stable", 32'(a_out_onehot), 32'h4);
      a_in_valid = 1'b0;
      step();
      chk("bp_hold_valid", 32'(a_out_valid),  32'd1);
      chk("bp_hold_head",  32'(a_out_onehot), 32'h4);
      chk("bp_hold_cnt",   32'(a_cnt),        32'd4);
      a_out_ready = 1'b1;
      step();
      chk("bp_second",     32'(a_out_onehot), 32'h2);
      chk("bp_ready_back", 32'(a_in_ready),   32'd1);
      step();
      chk("bp_empty",      32'(a_out_valid),  32'd0);
      chk("bp_cnt",        32'(a_cnt),        32'd6);

      // clr collision: build seen=0011, cnt=7, then pop 1000 with clr
      a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      chk("clr_seen", 32'(a_seen), 32'd0);
      chk("clr_cnt",  32'(a_cnt),  32'd0);
      for (int i = 0; i < 7; i++) begin
         a_in_valid = 1'b1;
         a_in_idx   = clr_idx[i];
         step();
      end
      a_in_valid = 1'b0;
      step();
      chk("pre_coll_seen", 32'(a_seen), 32'h3);
      chk("pre_coll_cnt",  32'(a_cnt),  32'd7);
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_idx = 2'd3;
      step();
      a_in_valid = 1'b0;
      chk("coll_head", 32'(a_out_onehot), 32'h8);
      a_clr = 1'b1; a_out_ready = 1'b1;
      step();
      a_clr = 1'b0;
      chk("coll_seen",  32'(a_seen),      32'h8);
      chk("coll_cnt",   32'(a_cnt),       32'd1);
      chk("coll_empty", 32'(a_out_valid), 32'd0);

      // en gating: buffered beat drains, nothing new accepted
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_idx = 2'd2;
      step();
      a_en = 1'b0; a_in_idx = 2'd3;
      #1;
      chk("en_ready_low", 32'(a_in_ready), 32'd0);
      a_out_ready = 1'b1;
      step();
      chk("en_drained", 32'(a_out_valid), 32'd0);
      chk("en_cnt",     32'(a_cnt),       32'd2);
      chk("en_seen",    32'(a_seen),      32'hC);
      step();
      chk("en_no_accept", 32'(a_out_valid), 32'd0);
      a_in_valid = 1'b0; a_en = 1'b1;

      // Out-of-range and counter wrap on N=5, CNT_W=2
      b_out_ready = 1'b1;
      b_in_valid = 1'b1; b_in_idx = 3'd6;
      step();
      chk("oor_valid",  32'(b_out_valid),  32'd1);
      chk("oor_onehot", 32'(b_out_onehot), 32'd0);
      chk("oor_err",    32'(b_out_err),    32'd1);
      b_in_valid = 1'b0;
      step();
      chk("oor_cnt",  32'(b_cnt),  32'd1);
      chk("oor_seen", 32'(b_seen), 32'd0);
      for (int i = 0; i < 3; i++) begin
         b_in_valid = 1'b1;
         b_in_idx   = b_idx[i];
         step();
         chk("b_onehot", 32'(b_out_onehot), 32'(b_exp[i]));
         chk("b_err",    32'(b_out_err),    32'd0);
      end
      b_in_valid = 1'b0;
      step();
      chk("wrap_cnt",  32'(b_cnt),  32'd0);
      chk("wrap_seen", 32'(b_seen), 32'h13);

      // Reset mid-stream with both entries full
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_idx = 2'd0;
      step();
      a_in_idx = 2'd1;
      step();
      a_in_valid = 1'b0;
      chk("mid_full", 32'(a_in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
      chk("mid_rst_cnt",   32'(a_cnt),       32'd0);
      chk("mid_rst_seen",  32'(a_seen),      32'd0);
      step();
      rst_n = 1'b1;
      a_out_ready = 1'b1;
      step();
      chk("mid_after_valid", 32'(a_out_valid), 32'd0);
      chk("mid_after_ready", 32'(a_in_ready),  32'd1);
      chk("mid_after_cnt",   32'(a_cnt),       32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
